// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, instruction memory requester and prefetch FIFO for the MIPS front end
// Optional macro FETCH_PERF_EN adds the FetchCount/StallCount counters.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Halt,
`ifdef FETCH_PERF_EN
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount,
`endif
  output logic        Halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
  state_t state, state_next;

  logic [31:0]   pc;
  logic          inflight;
  logic [31:0]   inflight_addr;
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_addr [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   last_instr, last_pc, last_pc4;
  logic          pop, push, req;
  logic [CW-1:0] credit_used;

  assign InstrValid  = (count != '0);
  assign pop         = InstrValid & InstrReady;
  // A response whose request was followed by a redirect is dropped.
  assign push        = inflight & ~Redirect;
  assign credit_used = count + CW'(inflight) - CW'(pop);
  assign req         = (state == S_RUN) && !Redirect && (credit_used < CW'(DEPTH));

  assign IMemReq     = req;
  assign IMemAddr    = pc;
  assign Halted      = (state == S_HALT);

  // Head falls through from storage; when empty the last shown values are held.
  assign Instruction = InstrValid ? mem_data[rd_ptr] : last_instr;
  assign InstrPC     = InstrValid ? mem_addr[rd_ptr] : last_pc;
  assign PCPlus4     = InstrValid ? mem_addr[rd_ptr] + 32'd4 : last_pc4;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_RUN;
      S_RUN:   if (!Redirect && Halt) state_next = S_HALT;
      S_HALT:  if (Redirect) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= 32'h0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      last_instr    <= 32'h0;
      last_pc       <= 32'h0;
      last_pc4      <= 32'h0;
    end else begin
      state <= state_next;
      if (InstrValid) begin
        last_instr <= Instruction;
        last_pc    <= InstrPC;
        last_pc4   <= PCPlus4;
      end
      if (Redirect) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        inflight <= 1'b0;
        pc       <= RedirectPC & 32'hFFFF_FFFC;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count    <= count + CW'(push) - CW'(pop);
        inflight <= req;
        if (req) begin
          inflight_addr <= pc;
          pc            <= pc + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst && push) begin
      mem_data[wr_ptr] <= IMemRData;
      mem_addr[wr_ptr] <= inflight_addr;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      FetchCount <= 32'h0;
      StallCount <= 32'h0;
    end else begin
      if (pop) FetchCount <= FetchCount + 32'd1;
      if (state == S_RUN && !InstrValid) StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the MIPS pipeline: owns the PC, issues word reads to the synchronous instruction memory, and buffers returned words in a small prefetch FIFO.
- Presents the FIFO head to the decode/control stage through a valid/ready handshake.
- Supports branch/jump redirect (flush) and a halt request.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of 2, >= 2
RESET_PC, 32'h00000000, PC loaded at reset

Ports:
Clk  input  1  clock, all state updates on posedge
Rst  input  1  synchronous reset, active-low (0 = reset)
IMemReq  output  1  read request to instruction memory this cycle
IMemAddr  output  32  word address of request, [1:0] always 00
IMemRData  input  32  read data, valid exactly 1 cycle after IMemReq
Instruction  output  32  FIFO head instruction word
InstrPC  output  32  PC of head instruction
PCPlus4  output  32  InstrPC + 4, modulo 2^32
InstrValid  output  1  head entry valid
InstrReady  input  1  decode stage accepts head
Redirect  input  1  flush and restart at RedirectPC
RedirectPC  input  32  new PC; bits [1:0] ignored, forced to 00
Halt  input  1  stop issuing new fetches
Halted  output  1  FSM in S_HALT

Behaviour:
- Reset (Rst=0 at posedge):
  - PC=RESET_PC; FIFO empty; in-flight flag=0; FSM=S_IDLE.
  - IMemReq=0, IMemAddr=RESET_PC, InstrValid=0, Instruction=0, InstrPC=0, PCPlus4=0, Halted=0.
  - A reset mid-operation discards all buffered and in-flight data.
- FSM:
  - S_IDLE: one cycle after reset, no request; goes to S_RUN.
  - S_RUN: issue requests per the credit rule. Halt=1 -> S_HALT.
  - S_HALT: IMemReq=0. An in-flight response is still captured and buffered entries still drain. Redirect=1 -> S_RUN. Halt deasserting alone does not resume.
- Credit rule:
  - IMemReq=1 in S_RUN iff (count + inflight - pop) < DEPTH and Redirect=0.
  - pop = InstrValid & InstrReady.
  - On request: IMemAddr=PC, PC <= PC+4 (wraps 32'hFFFFFFFC -> 0), inflight <= 1.
- Capture:
  - The cycle after a request, IMemRData and its address are written to the FIFO tail at posedge unless the in-flight flag was cleared by Redirect.
  - FIFO can never overflow; push while full is impossible by construction.
- Latency: request in cycle t -> data cycle t+1 -> InstrValid=1 in cycle t+2. With InstrReady held high, sustained throughput is 1 instruction/cycle after fill.
- Output:
  - First-word-fall-through from registered storage; Instruction, InstrPC and PCPlus4 stable while InstrValid=1 and InstrReady=0.
  - When empty, InstrValid=0 and data outputs hold their last values.
- Simultaneous push and pop: both take effect; count unchanged.
- Redirect (cycle t):
  - FIFO cleared; in-flight response dropped; PC <= {RedirectPC[31:2],2'b00}; no request in cycle t.
  - Request issued in t+1; InstrValid in t+3.
  - A pop in cycle t still counts as accepted by decode.
  - Redirect has priority over Halt in the same cycle (FSM -> S_RUN).

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs FetchCount[31:0] (increments on each pop) and StallCount[31:0] (increments each cycle InstrValid=0 in S_RUN). Both counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, RESET_PC=0, memory returns addr+32'h1000, InstrReady=1 -> IMemAddr sequence 0,4,8,...; first InstrValid 2 cycles after first IMemReq; Instruction 32'h1000,32'h1004,... one per cycle; PCPlus4=InstrPC+4.
- InstrReady=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, IMemReq=0 thereafter, head stays 32'h1000 at InstrPC=0. Raising InstrReady resumes at address 16 with no loss or duplication.
- Redirect=1 with RedirectPC=32'h00000403 while FIFO holds 3 entries -> InstrValid=0 next cycle; next IMemAddr=32'h400; InstrValid=1 three cycles after Redirect with InstrPC=32'h400; no pre-redirect word ever appears.
- Halt=1 with one request in flight -> Halted=1; in-flight word delivered; no further IMemReq. Halt=0 alone does not resume; Redirect to 32'h80 resumes fetch at 32'h80.
- RESET_PC=32'hFFFFFFF8 -> addresses FFFFFFF8, FFFFFFFC, 00000000; PCPlus4 of the FFFFFFFC entry = 0.
- Rst=0 asserted mid-stream with 2 buffered entries and FETCH_PERF_EN defined -> next cycle InstrValid=0, IMemReq=0, FetchCount=0, StallCount=0; refetch begins at RESET_PC.
